// File: rtl/stupidrv_mem_responder.sv
// Word-organised RAM serving one instruction fetch and one data access per cycle, with
// programmable data wait states. Define MEM_CONSOLE_EN to map a console register at CONSOLE_ADDR.
module stupidrv_mem_responder #(
    parameter int          MEM_WORDS     = 4096,
    parameter              MEM_INIT_FILE = "",
    parameter int          WAIT_CYCLES   = 0,
    parameter logic [31:0] CONSOLE_ADDR  = 32'h1000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        stall,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [31:0] ram [MEM_WORDS];

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          stall_c;
    logic          complete;
    logic          con_hit;
    logic          wr_en;
    logic [AW-1:0] iidx, didx;
    logic [31:0]   imem_data_q;
    logic [31:0]   dmem_rdata_q;

    assign iidx = imem_addr[AW+1:2];
    assign didx = dmem_addr[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmem_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped request is abandoned without writing anything.
                if (!dmem_valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall is released the instant reset asserts, even with a request pending.
    assign stall = stall_c & resetn;
    assign wr_en = complete & resetn & (|dmem_wstrb) & ~con_hit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            imem_data_q  <= 32'd0;
            dmem_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!stall) imem_data_q <= ram[iidx];
            if (complete && dmem_wstrb == 4'd0) dmem_rdata_q <= con_hit ? 32'd0 : ram[didx];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb[i]) ram[didx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
        end
    end

    assign imem_data  = imem_data_q;
    assign dmem_rdata = dmem_rdata_q;

`ifdef MEM_CONSOLE_EN
    logic       console_valid_q;
    logic [7:0] console_data_q;
    logic       con_wr;

    function automatic logic [7:0] lowest_lane(input logic [3:0] strb, input logic [31:0] data);
        logic [7:0] b;
        b = data[31:24];
        if (strb[2]) b = data[23:16];
        if (strb[1]) b = data[15:8];
        if (strb[0]) b = data[7:0];
        return b;
    endfunction

    assign con_hit = (dmem_addr[31:2] == CONSOLE_ADDR[31:2]);
    assign con_wr  = complete & con_hit & (|dmem_wstrb);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            console_valid_q <= 1'b0;
            console_data_q  <= 8'd0;
        end else begin
            console_valid_q <= con_wr;
            if (con_wr) console_data_q <= lowest_lane(dmem_wstrb, dmem_wdata);
        end
    end

    assign console_valid = console_valid_q;
    assign console_data  = console_data_q;

    logic unused_bits;
    assign unused_bits = ^{imem_addr[1:0], dmem_addr[1:0]};
`else
    assign con_hit       = 1'b0;
    assign console_valid = 1'b0;
    assign console_data  = 8'd0;

    logic unused_bits;
    assign unused_bits = ^{imem_addr[1:0], imem_addr[31:AW+2], dmem_addr[1:0],
                           dmem_addr[31:AW+2], CONSOLE_ADDR};
`endif

endmodule
